// File: rtl/sdram_write_burst_fifo_pkg.sv
// Shared types and widths for the SDRAM write burst FIFO.
// Imported by the RAM, the interface and the top level.
package sdram_wr_pkg;

  localparam int DATA_W       = 16;
  localparam int DEPTH        = 64;
  localparam int PTR_W        = 6;
  localparam int BURST_LEN    = 8;
  localparam int SDRAM_ADDR_W = 24;
  localparam int BURST_LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER
  } state_t;

  typedef logic [DATA_W-1:0]       word_t;
  typedef logic [SDRAM_ADDR_W-1:0] addr_t;
  typedef logic [BURST_LEN_W-1:0]  blen_t;
  typedef logic [PTR_W-1:0]        ptr_t;
  typedef logic [PTR_W:0]          cnt_t;

endpackage

// File: rtl/sdram_write_burst_fifo_if.sv
// Controller-side burst handshake of the write burst FIFO.
// The FIFO is the slave; the SDRAM controller is the master.
interface sdram_write_burst_fifo_if;
  import sdram_wr_pkg::*;

  logic  burst_req;
  addr_t burst_addr;
  blen_t burst_len;
  logic  burst_ack;
  logic  word_rd;
  word_t q;
  logic  burst_done;

  modport slave (
    output burst_req,
    output burst_addr,
    output burst_len,
    output q,
    output burst_done,
    input  burst_ack,
    input  word_rd
  );

  modport master (
    input  burst_req,
    input  burst_addr,
    input  burst_len,
    input  q,
    input  burst_done,
    output burst_ack,
    output word_rd
  );

endinterface

// File: rtl/sdram_write_burst_fifo_ram.sv
// Simple dual-port word store with a registered head output.
// A write to the slot being read is forwarded to the output.
module sdram_wr_ram
  import sdram_wr_pkg::*;
(
  input  logic  clock,
  input  logic  aclr,
  input  logic  we,
  input  ptr_t  waddr,
  input  word_t wdata,
  input  logic  re,
  input  ptr_t  raddr,
  output word_t rdata
);

  word_t mem [DEPTH];

  // array write port
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // head register: forward same-slot writes, else read on request
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      rdata <= '0;
    end else if (we && waddr == raddr) begin
      rdata <= wdata;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sdram_write_burst_fifo.sv
// Client word buffer presented to the SDRAM controller
// as address-tagged write bursts.
module sdram_write_burst_fifo
  import sdram_wr_pkg::*;
(
  input  logic  clock,
  input  logic  aclr,
  input  word_t data,
  input  logic  wrreq,
  output logic  full,
  output cnt_t  usedw,
  input  addr_t start_addr,
  input  logic  addr_load,
  input  logic  flush,
  output logic  overflow,
  output logic  underflow,
  sdram_write_burst_fifo_if.slave ctl
);

  localparam cnt_t  DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t  BL_C    = cnt_t'(BURST_LEN);
  localparam blen_t BL_B    = blen_t'(BURST_LEN);

  ptr_t   wr_ptr, rd_ptr, raddr;
  cnt_t   count_q, cnt_d;
  logic   full_q, wr_ok, pop;
  state_t state_q, state_d;
  addr_t  addr_q, addr_d;
  addr_t  baddr_q, baddr_d;
  blen_t  blen_q, blen_d;
  blen_t  rem_q, rem_d;
  logic   flush_q, flush_d;
  logic   done_q, done_d;
  logic   req_q;
  logic   ovf_q, udf_q;

  assign wr_ok = wrreq && !full_q;
  assign pop   = ctl.word_rd && state_q == XFER
              && count_q != '0;
  assign cnt_d = count_q + cnt_t'(wr_ok)
               - cnt_t'(pop);
  assign raddr = pop ? rd_ptr + ptr_t'(1) : rd_ptr;

  sdram_wr_ram u_ram (
    .clock (clock),
    .aclr  (aclr),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data),
    .re    (pop),
    .raddr (raddr),
    .rdata (ctl.q)
  );

  // pointers, occupancy and sticky error flags
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)   rd_ptr <= rd_ptr + ptr_t'(1);
      count_q <= cnt_d;
      full_q  <= cnt_d == DEPTH_C;
      if (wrreq && full_q)   ovf_q <= 1'b1;
      if (ctl.word_rd && !pop) udf_q <= 1'b1;
    end
  end

  // burst sequencing, address generation, flush tracking
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    baddr_d = baddr_q;
    blen_d  = blen_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    flush_d = flush_q;
    unique case (state_q)
      IDLE: begin
        if (addr_load) addr_d = start_addr;
        if (count_q >= BL_C) begin
          state_d = REQ;
          blen_d  = BL_B;
          baddr_d = addr_d;
        end else if (flush_q && count_q != '0) begin
          state_d = REQ;
          blen_d  = blen_t'(count_q);
          baddr_d = addr_d;
        end
      end
      REQ: begin
        if (ctl.burst_ack) begin
          state_d = XFER;
          rem_d   = blen_q;
        end
      end
      XFER: begin
        if (pop) begin
          rem_d = rem_q - blen_t'(1);
          if (rem_q == blen_t'(1)) begin
            state_d = IDLE;
            addr_d  = addr_q + addr_t'(blen_q);
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_d == IDLE
        && cnt_d == '0) flush_d = 1'b0;
    if (flush) flush_d = 1'b1;
  end

  // FSM and burst descriptor registers
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q <= IDLE;
      addr_q  <= '0;
      baddr_q <= '0;
      blen_q  <= '0;
      rem_q   <= '0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      baddr_q <= baddr_d;
      blen_q  <= blen_d;
      rem_q   <= rem_d;
      flush_q <= flush_d;
      done_q  <= done_d;
      req_q   <= state_d == REQ;
    end
  end

  assign usedw          = count_q;
  assign full           = full_q;
  assign overflow       = ovf_q;
  assign underflow      = udf_q;
  assign ctl.burst_req  = req_q;
  assign ctl.burst_addr = baddr_q;
  assign ctl.burst_len  = blen_q;
  assign ctl.burst_done = done_q;

endmodule

// File: tb/tb_sdram_write_burst_fifo.sv
// Directed bench for the write burst FIFO with a queue-based
// reference model checked every cycle.
module tb_sdram_write_burst_fifo;
  import sdram_wr_pkg::*;

  logic        clock = 1'b0;
  logic        aclr;
  logic [15:0] data;
  logic        wrreq;
  logic        full;
  logic [6:0]  usedw;
  logic [23:0] start_addr;
  logic        addr_load;
  logic        flush;
  logic        overflow;
  logic        underflow;

  sdram_write_burst_fifo_if ctl ();

  sdram_write_burst_fifo dut (
    .clock      (clock),
    .aclr       (aclr),
    .data       (data),
    .wrreq      (wrreq),
    .full       (full),
    .usedw      (usedw),
    .start_addr (start_addr),
    .addr_load  (addr_load),
    .flush      (flush),
    .overflow   (overflow),
    .underflow  (underflow),
    .ctl        (ctl)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  // reference model: word queue, sticky flags, burst progress
  logic [15:0] m_q[$];
  bit          m_ovf  = 0;
  bit          m_udf  = 0;
  bit          m_done = 0;
  bit          m_xfer = 0;
  int          m_rem  = 0;
  int          m_len  = 0;
  logic [23:0] m_addr = '0;

  always @(posedge clock or posedge aclr) begin
    bit was_full;
    bit do_pop;
    if (aclr) begin
      m_q.delete();
      m_ovf  = 0;
      m_udf  = 0;
      m_done = 0;
      m_xfer = 0;
      m_rem  = 0;
      m_addr = '0;
    end else begin
      was_full = (m_q.size() == 64);
      do_pop   = ctl.word_rd && m_xfer
              && m_q.size() > 0;
      m_done = 0;
      if (wrreq && was_full) m_ovf = 1;
      if (ctl.word_rd && !do_pop) m_udf = 1;
      if (do_pop) begin
        void'(m_q.pop_front());
        m_rem--;
        if (m_rem == 0) begin
          m_xfer = 0;
          m_done = 1;
          m_addr = m_addr + 24'(m_len);
        end
      end
      if (wrreq && !was_full) m_q.push_back(data);
      if (ctl.burst_ack) begin
        m_xfer = 1;
        m_rem  = m_len;
      end
      if (addr_load && !m_xfer) m_addr = start_addr;
    end
  end

  // per-cycle comparison just after each active edge
  always @(posedge clock) begin
    #1;
    chk("usedw", usedw, m_q.size());
    chk("full", full, m_q.size() == 64);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
    chk("burst_done", ctl.burst_done, m_done);
    if (m_q.size() > 0) chk("q", ctl.q, m_q[0]);
    if (ctl.burst_done === 1'b1) n_done++;
  end

  task automatic wr_words(input logic [15:0] base,
                          input int n);
    for (int i = 0; i < n; i++) begin
      wrreq = 1'b1;
      data  = base + 16'(i);
      @(negedge clock);
    end
    wrreq = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
  endtask

  task automatic wait_req();
    int t;
    t = 0;
    while (ctl.burst_req !== 1'b1 && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk("req_seen", ctl.burst_req, 1);
  endtask

  task automatic run_burst(input logic [23:0] ea,
                           input int el,
                           input logic [15:0] first,
                           input bit wr_too,
                           input logic [15:0] wbase);
    int d0;
    wait_req();
    chk("burst_addr", ctl.burst_addr, ea);
    chk("burst_len", ctl.burst_len, el);
    chk("model_addr", m_addr, ea);
    m_len = el;
    d0 = n_done;
    ctl.burst_ack = 1'b1;
    @(negedge clock);
    ctl.burst_ack = 1'b0;
    chk("req_drop", ctl.burst_req, 0);
    for (int i = 0; i < el; i++) begin
      chk("q_word", ctl.q, first + 16'(i));
      ctl.word_rd = 1'b1;
      wrreq = wr_too;
      data  = wbase + 16'(i);
      @(negedge clock);
    end
    ctl.word_rd = 1'b0;
    wrreq = 1'b0;
    @(negedge clock);
    chk("done_count", n_done - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    aclr          = 1'b1;
    data          = '0;
    wrreq         = 1'b0;
    start_addr    = '0;
    addr_load     = 1'b0;
    flush         = 1'b0;
    ctl.burst_ack = 1'b0;
    ctl.word_rd   = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_usedw", usedw, 0);
    chk("rst_full", full, 0);
    chk("rst_req", ctl.burst_req, 0);
    chk("rst_addr", ctl.burst_addr, 0);
    chk("rst_len", ctl.burst_len, 0);
    chk("rst_q", ctl.q, 0);
    chk("rst_done", ctl.burst_done, 0);
    aclr = 1'b0;
    @(negedge clock);

    // full burst at a loaded address
    start_addr = 24'h000100;
    addr_load  = 1'b1;
    @(negedge clock);
    addr_load  = 1'b0;
    wr_words(16'h0001, 8);
    run_burst(24'h000100, 8, 16'h0001, 0, 0);
    chk("addr_after_b1", m_addr, 24'h000108);

    // short flushed burst
    wr_words(16'h00A0, 3);
    pulse_flush();
    run_burst(24'h000108, 3, 16'h00A0, 0, 0);
    chk("usedw_after_flush", usedw, 0);

    // steady occupancy with concurrent writes
    wr_words(16'h00B0, 5);
    pulse_flush();
    run_burst(24'h00010B, 5, 16'h00B0, 1, 16'h00B5);
    chk("usedw_steady", usedw, 5);
    run_burst(24'h000110, 5, 16'h00B5, 0, 0);
    chk("usedw_drained", usedw, 0);

    // pop attempt in IDLE
    wr_words(16'h00C0, 2);
    repeat (3) @(negedge clock);
    chk("no_req_2w", ctl.burst_req, 0);
    ctl.word_rd = 1'b1;
    @(negedge clock);
    ctl.word_rd = 1'b0;
    @(negedge clock);
    chk("udf_set", underflow, 1);
    chk("udf_usedw", usedw, 2);
    chk("udf_q", ctl.q, 16'h00C0);
    pulse_flush();
    run_burst(24'h000115, 2, 16'h00C0, 0, 0);

    // fill past capacity
    wr_words(16'h1000, 65);
    chk("fill_usedw", usedw, 64);
    chk("fill_full", full, 1);
    chk("fill_ovf", overflow, 1);
    for (int k = 0; k < 8; k++) begin
      run_burst(24'h000117 + 24'(8 * k), 8,
                16'h1000 + 16'(8 * k), 0, 0);
    end
    chk("fill_drained", usedw, 0);
    chk("fill_full_clr", full, 0);

    // address wrap at the top of the space
    start_addr = 24'hFFFFF8;
    addr_load  = 1'b1;
    @(negedge clock);
    addr_load  = 1'b0;
    wr_words(16'h00D0, 8);
    run_burst(24'hFFFFF8, 8, 16'h00D0, 0, 0);
    wr_words(16'h00E0, 8);
    run_burst(24'h000000, 8, 16'h00E0, 0, 0);

    // reset in the middle of a transfer
    wr_words(16'h00F0, 8);
    wait_req();
    chk("mid_addr", ctl.burst_addr, 24'h000008);
    m_len = 8;
    ctl.burst_ack = 1'b1;
    @(negedge clock);
    ctl.burst_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ctl.word_rd = 1'b1;
      @(negedge clock);
    end
    ctl.word_rd = 1'b0;
    d0 = n_done;
    #2 aclr = 1'b1;
    #1;
    chk("arst_usedw", usedw, 0);
    chk("arst_full", full, 0);
    chk("arst_req", ctl.burst_req, 0);
    chk("arst_addr", ctl.burst_addr, 0);
    chk("arst_len", ctl.burst_len, 0);
    chk("arst_q", ctl.q, 0);
    chk("arst_done", ctl.burst_done, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_udf", underflow, 0);
    repeat (3) @(negedge clock);
    aclr = 1'b0;
    repeat (2) @(negedge clock);
    chk("arst_no_done", n_done - d0, 0);
    wr_words(16'h55AA, 1);
    chk("first_wr_q", ctl.q, 16'h55AA);
    chk("first_wr_usedw", usedw, 1);
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_write_burst_fifo.md
Name: sdram_write_burst_fifo

Overview:
Write-direction counterpart of the SDRAM read FIFO. Buffers 16-bit words from a client and presents them to the SDRAM controller as address-tagged write bursts. An internal show-ahead FIFO holds the words, a burst FSM requests bursts, and an address generator advances after each burst. The controller pops words one per cycle while it issues WRITE commands.

Parameters:
DATA_W, 16, data word width
DEPTH, 64, FIFO depth in words (power of 2)
PTR_W, 6, log2(DEPTH)
BURST_LEN, 8, words per full burst (1..15, ≤ DEPTH)
SDRAM_ADDR_W, 24, SDRAM word address width

Ports:
clock  in  1  system clock, rising edge
aclr  in  1  asynchronous active-high reset
data  in  DATA_W  client write word
wrreq  in  1  client write strobe
full  out  1  FIFO holds DEPTH words
usedw  out  PTR_W+1  FIFO word count, 0..DEPTH
start_addr  in  SDRAM_ADDR_W  base address for the next burst
addr_load  in  1  pulse: load start_addr
flush  in  1  pulse: drain residual words as a short burst
burst_req  out  1  burst request to the controller
burst_addr  out  SDRAM_ADDR_W  burst start address
burst_len  out  4  words in this burst, 1..BURST_LEN
burst_ack  in  1  controller accepts the request (1 cycle)
word_rd  in  1  controller pops the head word
q  out  DATA_W  head word (show-ahead)
burst_done  out  1  1-cycle pulse after the last word of a burst is popped
overflow  out  1  sticky: wrreq was seen while full
underflow  out  1  sticky: word_rd was seen outside XFER or while empty

Behaviour:
- Reset (aclr high, asynchronous):
  - Pointers and count cleared; usedw=0, full=0.
  - FSM=IDLE; address register=0; flush_pending=0.
  - burst_req=0, burst_addr=0, burst_len=0, burst_done=0, overflow=0, underflow=0.
  - q=0 until the first write.
  - Reset mid-burst abandons the burst and discards FIFO contents.
- FIFO storage:
  - Inferred dual-port RAM, DEPTH x DATA_W, with registered head output.
  - Write: wrreq && !full stores data and increments wr_ptr. A write while full is dropped and sets overflow.
  - Pop: word_rd && state==XFER && count>0 increments rd_ptr. Any other word_rd is ignored and sets underflow.
  - Simultaneous accepted write and pop: count unchanged.
  - Pointers wrap modulo DEPTH.
  - usedw and full are registered and update the cycle after the event.
  - q is valid whenever count>0. After a pop, q shows the next word one cycle later.
  - A write into an empty FIFO appears on q one cycle after wrreq.
- Address register:
  - addr_load is honoured only in IDLE; in REQ or XFER it is ignored.
  - After each burst: address += burst_len, modulo 2^SDRAM_ADDR_W.
- flush_pending:
  - Set by flush in any state.
  - Cleared on entry to IDLE when count==0.
- FSM:
  - IDLE:
    - If count ≥ BURST_LEN: latch burst_len=BURST_LEN and burst_addr=address, go to REQ.
    - Else if flush_pending && count>0: latch burst_len=count and burst_addr=address, go to REQ.
    - burst_req goes high the cycle after the condition is registered.
  - REQ:
    - burst_req=1; burst_addr and burst_len are held stable.
    - On burst_ack: go to XFER, load remaining=burst_len, drop burst_req the next cycle.
  - XFER:
    - Each accepted pop decrements remaining.
    - The pop that makes remaining 0 moves the FSM to IDLE, updates the address, and pulses burst_done on the following cycle.
  - Client writes continue in every state. A new request needs at least one IDLE cycle between bursts.
- burst_len: 4-bit field sized for BURST_LEN ≤ 15.

Decomposition:
- Package sdram_wr_pkg: state enum (IDLE/REQ/XFER), BURST_LEN_W=4 constant, default widths.
- One sub-module: sdram_wr_ram (simple dual-port RAM, registered read, 1 write port, 1 read port). The FSM, pointers and address generator stay in the top level.

Test Plan:
- Write 0x0001..0x0008 back-to-back after addr_load 0x000100 -> burst_req with addr 0x000100, len 8. After ack, 8 pops return 0x0001..0x0008 in order; burst_done pulses once; next burst_addr is 0x000108.
- Write 3 words 0xA0..0xA2, then flush -> burst_req with len 3 at the current address. After the pops, usedw=0, flush_pending clears, FSM returns to IDLE.
- Fill to 64 words, then 1 more wrreq -> full=1, usedw=64, overflow=1, 65th word absent from the pop stream.
- Pops while usedw holds at 5 during XFER with a concurrent wrreq -> usedw stays at 5, data order is preserved.
- word_rd in IDLE with 2 words buffered -> underflow=1, usedw stays 2, q unchanged.
- aclr asserted mid-XFER after 4 of 8 pops -> all outputs return to reset values immediately, usedw=0, no burst_done.
- addr_load 0xFFFFF8 then one full burst -> next burst_addr wraps to 0x000000.
